load_store_unit: RTL

- Memory stage of the RV32 pipeline, sitting directly upstream of write-back.
- Accepts one load/store from execute and runs a valid/ready request plus response transaction on the data bus.
- Aligns and sign/zero-extends load data into a registered 32-bit result that feeds write-back's memory-select input.
- Flags misaligned accesses, bus errors and response timeouts.

---
 rtl/load_store_unit_if.sv | 48 ++++
 rtl/load_store_unit.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit_if.sv
// Interface bundling the execute-side request, the data-bus request/response
// channels and the write-back-side result of the load/store unit.
//   master : the load/store unit's view (drives req_ready, bus request, result)
//   slave  : the environment's view (execute stage, memory bus, write-back)
// Signals:
//   req_valid/req_ready/req_is_store/req_funct3/req_addr/req_wdata  execute request
//   bus_valid/bus_ready/bus_we/bus_addr/bus_wdata/bus_wstrb         bus request
//   bus_rvalid/bus_rdata/bus_err                                    bus response
//   done/load_data/misaligned/bus_fault                             result
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        bus_valid;
  logic        bus_ready;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;
  logic        bus_err;

  logic        done;
  logic [31:0] load_data;
  logic        misaligned;
  logic        bus_fault;

  modport master (
    input  req_valid, req_is_store, req_funct3, req_addr, req_wdata,
    output req_ready,
    output bus_valid, bus_we, bus_addr, bus_wdata, bus_wstrb,
    input  bus_ready, bus_rvalid, bus_rdata, bus_err,
    output done, load_data, misaligned, bus_fault
  );

  modport slave (
    output req_valid, req_is_store, req_funct3, req_addr, req_wdata,
    input  req_ready,
    input  bus_valid, bus_we, bus_addr, bus_wdata, bus_wstrb,
    output bus_ready, bus_rvalid, bus_rdata, bus_err,
    input  done, load_data, misaligned, bus_fault
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32 memory stage. Accepts one load/store from execute, runs a request plus
// response transaction on the data bus, and returns an aligned, sign/zero
// extended load result to write-back. Misaligned or illegal ops, bus errors
// and response timeouts are reported through sticky flags.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   lsu         load_store_unit_if.master (request, bus, result signals)
// Parameters:
//   TIMEOUT_CYCLES  cycles waited in RESP for bus_rvalid before giving up
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  load_store_unit_if.master   lsu
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, FAULT} state_t;

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t state, state_next;

  logic [CNT_W-1:0] resp_cnt;
  logic             op_store;
  logic [2:0]       op_funct3;
  logic [1:0]       op_off;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [3:0]       wstrb_q;
  logic             we_q;
  logic             done_q;
  logic             misaligned_q;
  logic             bus_fault_q;
  logic [31:0]      load_data_q;

  logic             accept;
  logic             illegal;
  logic [31:0]      fmt_wdata;
  logic [3:0]       fmt_wstrb;
  logic             resp_hit;
  logic             resp_timeout;

  // Extracts the addressed lane from the read word and extends it to 32 bits.
  function automatic logic [31:0] extract(input logic [2:0] f3,
                                          input logic [1:0] off,
                                          input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'd0:    extract = {{24{b[7]}}, b};
      3'd1:    extract = {{16{h[15]}}, h};
      3'd4:    extract = {24'd0, b};
      3'd5:    extract = {16'd0, h};
      default: extract = w;
    endcase
  endfunction

  assign accept       = lsu.req_valid && (state == IDLE);
  assign resp_hit     = (state == RESP) && lsu.bus_rvalid;
  assign resp_timeout = (state == RESP) && !lsu.bus_rvalid &&
                        (resp_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Illegal funct3 or an access not aligned to its size goes to FAULT.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    illegal = 1'b0;
    if (lsu.req_is_store) begin
      if (lsu.req_funct3 > 3'd2) illegal = 1'b1;
    end else if (lsu.req_funct3 inside {3'd3, 3'd6, 3'd7}) begin
      illegal = 1'b1;
    end
    case (lsu.req_funct3[1:0])
      2'd1:    if (lsu.req_addr[0]) illegal = 1'b1;
      2'd2:    if (lsu.req_addr[1:0] != 2'b00) illegal = 1'b1;
      default: ;
    endcase
  end

  // Store data is replicated across lanes; the strobe selects the lane(s).
  always_comb begin
    fmt_wdata = lsu.req_wdata;
    fmt_wstrb = 4'b1111;
    case (lsu.req_funct3[1:0])
      2'd0: begin
        fmt_wdata = {4{lsu.req_wdata[7:0]}};
        fmt_wstrb = 4'b0001 << lsu.req_addr[1:0];
      end
      2'd1: begin
        fmt_wdata = {2{lsu.req_wdata[15:0]}};
        fmt_wstrb = lsu.req_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
    if (!lsu.req_is_store) fmt_wstrb = 4'b0000;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = illegal ? FAULT : REQ;
      REQ:     if (lsu.bus_ready) state_next = RESP;
      RESP:    if (resp_hit || resp_timeout) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from state; bus_valid follows the async-reset state
  // register, so it drops as soon as rst_n is asserted.
  always_comb begin
    lsu.req_ready = (state == IDLE);
    lsu.bus_valid = (state == REQ);
    lsu.done      = done_q || (state == FAULT);
  end

  assign lsu.bus_we     = we_q;
  assign lsu.bus_addr   = addr_q;
  assign lsu.bus_wdata  = wdata_q;
  assign lsu.bus_wstrb  = wstrb_q;
  assign lsu.load_data  = load_data_q;
  assign lsu.misaligned = misaligned_q;
  assign lsu.bus_fault  = bus_fault_q;

  // Latched op, response capture, sticky flags and the timeout counter.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: all datapath registers are reset because their reset values are
    // visible on the ports; there is no memory array here to leave unreset.
    if (!rst_n) begin
      op_store     <= 1'b0;
      op_funct3    <= 3'd0;
      op_off       <= 2'd0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      wstrb_q      <= 4'd0;
      we_q         <= 1'b0;
      done_q       <= 1'b0;
      misaligned_q <= 1'b0;
      bus_fault_q  <= 1'b0;
      load_data_q  <= 32'd0;
      resp_cnt     <= '0;
    end else begin
      done_q <= resp_hit || resp_timeout;

      if (accept) begin
        op_store     <= lsu.req_is_store;
        op_funct3    <= lsu.req_funct3;
        op_off       <= lsu.req_addr[1:0];
        addr_q       <= {lsu.req_addr[31:2], 2'b00};
        wdata_q      <= fmt_wdata;
        wstrb_q      <= fmt_wstrb;
        we_q         <= lsu.req_is_store;
        misaligned_q <= illegal;
        bus_fault_q  <= 1'b0;
      end

      // The counter restarts while the request is outstanding and counts
      // response-less cycles once the request has been accepted.
      if (state == REQ) begin
        resp_cnt <= '0;
      end else if ((state == RESP) && !lsu.bus_rvalid) begin
        resp_cnt <= resp_cnt + CNT_W'(1);
      end

      if (resp_hit) begin
        bus_fault_q <= lsu.bus_err;
        if (!op_store && !lsu.bus_err) begin
          load_data_q <= extract(op_funct3, op_off, lsu.bus_rdata);
        end
      end else if (resp_timeout) begin
        bus_fault_q <= 1'b1;
      end
    end
  end

endmodule
